reg_req_rr_arbiter: RTL and testbench

//  Shares one reg-bus master port (the reg_to_axi bridge input) between NumReq reg-bus requesters.

---
 rtl/reg_req_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_reg_req_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_req_rr_arbiter.sv
// Round-robin arbiter that shares one reg-bus master port between NumReq requesters.
// One transaction is in flight at a time. An optional watchdog error-completes a stuck request and then drains it.
module reg_req_rr_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq*AddrWidth-1:0]        in_req_addr,
    input  logic [NumReq-1:0]                  in_req_write,
    input  logic [NumReq*DataWidth-1:0]        in_req_wdata,
    input  logic [NumReq*(DataWidth/8)-1:0]    in_req_wstrb,
    input  logic [NumReq-1:0]                  in_req_valid,
    output logic [NumReq*DataWidth-1:0]        in_rsp_rdata,
    output logic [NumReq-1:0]                  in_rsp_error,
    output logic [NumReq-1:0]                  in_rsp_ready,
    output logic [AddrWidth-1:0]               out_req_addr,
    output logic                               out_req_write,
    output logic [DataWidth-1:0]               out_req_wdata,
    output logic [DataWidth/8-1:0]             out_req_wstrb,
    output logic                               out_req_valid,
    input  logic [DataWidth-1:0]               out_rsp_rdata,
    input  logic                               out_rsp_error,
    input  logic                               out_rsp_ready,
    output logic [NumReq-1:0]                  grant_o,
    output logic                               timeout_o
);
    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned IdxWidth   = $clog2(NumReq);
    localparam int unsigned TimerWidth = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam bit          WdogEn     = (TimeoutCycles != 0);
    localparam logic [TimerWidth-1:0] TimerLast = WdogEn ? TimerWidth'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]   owner_q, owner_d;
    logic [NumReq-1:0]     grant_q, grant_d;
    logic                  valid_q, valid_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
    logic [TimerWidth-1:0] timer_q, timer_d;

    logic [AddrWidth-1:0]  req_addr  [NumReq];
    logic [DataWidth-1:0]  req_wdata [NumReq];
    logic [StrbWidth-1:0]  req_wstrb [NumReq];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
        assign req_addr[gi]  = in_req_addr[gi*AddrWidth +: AddrWidth];
        assign req_wdata[gi] = in_req_wdata[gi*DataWidth +: DataWidth];
        assign req_wstrb[gi] = in_req_wstrb[gi*StrbWidth +: StrbWidth];
    end

    // Rotate the valid vector so that bit 0 is rr_ptr, then take the lowest set bit.
    logic [2*NumReq-1:0]   valid_dbl;
    logic [NumReq-1:0]     valid_rot;
    logic [IdxWidth-1:0]   pick_off;
    logic [IdxWidth:0]     pick_sum;
    logic [IdxWidth-1:0]   pick_idx;

    always_comb begin
        valid_dbl = {in_req_valid, in_req_valid} >> rr_ptr_q;
        valid_rot = valid_dbl[NumReq-1:0];
        pick_off  = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (valid_rot[k]) pick_off = IdxWidth'(k);
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (IdxWidth+1)'(NumReq)) pick_sum = pick_sum - (IdxWidth+1)'(NumReq);
        pick_idx = pick_sum[IdxWidth-1:0];
    end

    logic                rsp_done;
    logic                rsp_tmo;
    logic [IdxWidth-1:0] next_ptr;

    // A bridge response in the expiry cycle takes priority over the watchdog.
    assign rsp_done = (state_q == StBusy) && out_rsp_ready;
    assign rsp_tmo  = WdogEn && (state_q == StBusy) && !out_rsp_ready && (timer_q == TimerLast);
    assign next_ptr = (owner_q == IdxWidth'(NumReq - 1)) ? '0 : owner_q + IdxWidth'(1);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        timer_d  = timer_q;
        unique case (state_q)
            StIdle: begin
                if (|in_req_valid) begin
                    state_d = StBusy;
                    owner_d = pick_idx;
                    grant_d = NumReq'(1) << pick_idx;
                    valid_d = 1'b1;
                    addr_d  = req_addr[pick_idx];
                    write_d = in_req_write[pick_idx];
                    wdata_d = req_wdata[pick_idx];
                    wstrb_d = req_wstrb[pick_idx];
                    timer_d = '0;
                end
            end
            StBusy: begin
                if (rsp_done || rsp_tmo) rr_ptr_d = next_ptr;
                if (rsp_done) begin
                    state_d = StIdle;
                    grant_d = '0;
                    valid_d = 1'b0;
                end else if (rsp_tmo) begin
                    state_d = StDrain;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end
            StDrain: begin
                if (out_rsp_ready) begin
                    state_d = StIdle;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            timer_q  <= timer_d;
        end
    end

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_rsp
        logic sel;
        assign sel              = (rsp_done || rsp_tmo) && (owner_q == IdxWidth'(gi));
        assign in_rsp_ready[gi] = sel;
        assign in_rsp_error[gi] = sel && (rsp_tmo || out_rsp_error);
        assign in_rsp_rdata[gi*DataWidth +: DataWidth] = (sel && rsp_done) ? out_rsp_rdata : '0;
    end

    assign out_req_addr  = addr_q;
    assign out_req_write = write_q;
    assign out_req_wdata = wdata_q;
    assign out_req_wstrb = wstrb_q;
    assign out_req_valid = valid_q;
    assign grant_o       = grant_q;
    assign timeout_o     = rsp_tmo;

endmodule

// File: tb/tb_reg_req_rr_arbiter.sv
// Bench for reg_req_rr_arbiter: directed scenarios with literal expectations, then random traffic.
// A transaction-level model (owner index, elapsed busy cycles, rotation pointer) is checked every cycle.
module tb_reg_req_rr_arbiter;
    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic              clk;
    logic              rst_ni;
    logic [N*AW-1:0]   in_req_addr;
    logic [N-1:0]      in_req_write;
    logic [N*DW-1:0]   in_req_wdata;
    logic [N*DW/8-1:0] in_req_wstrb;
    logic [N-1:0]      in_req_valid;
    logic [N*DW-1:0]   in_rsp_rdata;
    logic [N-1:0]      in_rsp_error;
    logic [N-1:0]      in_rsp_ready;
    logic [AW-1:0]     out_req_addr;
    logic              out_req_write;
    logic [DW-1:0]     out_req_wdata;
    logic [DW/8-1:0]   out_req_wstrb;
    logic              out_req_valid;
    logic [DW-1:0]     out_rsp_rdata;
    logic              out_rsp_error;
    logic              out_rsp_ready;
    logic [N-1:0]      grant_o;
    logic              timeout_o;

    reg_req_rr_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_req_addr(in_req_addr), .in_req_write(in_req_write), .in_req_wdata(in_req_wdata),
        .in_req_wstrb(in_req_wstrb), .in_req_valid(in_req_valid),
        .in_rsp_rdata(in_rsp_rdata), .in_rsp_error(in_rsp_error), .in_rsp_ready(in_rsp_ready),
        .out_req_addr(out_req_addr), .out_req_write(out_req_write), .out_req_wdata(out_req_wdata),
        .out_req_wstrb(out_req_wstrb), .out_req_valid(out_req_valid),
        .out_rsp_rdata(out_rsp_rdata), .out_rsp_error(out_rsp_error), .out_rsp_ready(out_rsp_ready),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] s);
        in_req_write[i]        = w;
        in_req_addr[i*AW +: AW] = a;
        in_req_wdata[i*DW +: DW] = d;
        in_req_wstrb[i*8 +: 8]   = s;
    endtask

    // Transaction-level model: who owns the bus, whether it is being drained,
    // how many busy cycles have elapsed, and where the next search starts.
    bit           m_ok = 0;
    int           m_owner = -1;
    bit           m_drain = 0;
    int           m_cnt = 0;
    int           m_rr = 0;
    logic [63:0]  m_addr, m_wdata;
    logic [7:0]   m_wstrb;
    logic         m_write;
    bit           m_busy, m_fin, m_tmo, m_found;
    logic [3:0]   e_grant, e_rdy, e_err;
    logic [255:0] e_rdata;

    always @(negedge clk) begin
        if (m_ok) begin
            m_busy  = (m_owner >= 0) && !m_drain;
            m_fin   = m_busy && out_rsp_ready;
            m_tmo   = m_busy && !out_rsp_ready && (m_cnt == TMO - 1);
            e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            e_rdy   = (m_fin || m_tmo) ? (4'b0001 << m_owner) : 4'b0000;
            e_err   = m_fin ? ({3'b000, out_rsp_error} << m_owner) : (m_tmo ? e_rdy : 4'b0000);
            e_rdata = '0;
            if (m_fin) e_rdata[m_owner*DW +: DW] = out_rsp_rdata;
            check("mdl_grant", grant_o, e_grant);
            check("mdl_out_valid", out_req_valid, m_owner >= 0);
            check("mdl_timeout", timeout_o, m_tmo);
            check("mdl_rsp_ready", in_rsp_ready, e_rdy);
            check("mdl_rsp_error", in_rsp_error, e_err);
            check("mdl_rsp_rdata", in_rsp_rdata, e_rdata);
            if (m_owner >= 0) begin
                check("mdl_addr", out_req_addr, m_addr);
                check("mdl_write", out_req_write, m_write);
                check("mdl_wdata", out_req_wdata, m_wdata);
                check("mdl_wstrb", out_req_wstrb, m_wstrb);
            end
        end
        // Advance the model to what the coming rising edge produces.
        if (!rst_ni) begin
            m_ok = 1; m_owner = -1; m_drain = 0; m_cnt = 0; m_rr = 0;
        end else if (m_ok) begin
            if (m_owner < 0) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (!m_found && in_req_valid[c]) begin
                        m_found = 1;
                        m_owner = c;
                        m_cnt   = 0;
                        m_addr  = in_req_addr[c*AW +: AW];
                        m_wdata = in_req_wdata[c*DW +: DW];
                        m_wstrb = in_req_wstrb[c*8 +: 8];
                        m_write = in_req_write[c];
                    end
                end
            end else if (!m_drain) begin
                if (out_rsp_ready || m_cnt == TMO - 1) begin
                    m_rr = (m_owner + 1) % N;
                    if (out_rsp_ready) m_owner = -1;
                    else m_drain = 1;
                end else begin
                    m_cnt++;
                end
            end else if (out_rsp_ready) begin
                m_owner = -1;
                m_drain = 0;
            end
        end
    end

    logic [255:0] exp_rd;

    initial begin
        rst_ni = 0; in_req_addr = '0; in_req_write = '0; in_req_wdata = '0;
        in_req_wstrb = '0; in_req_valid = '0;
        out_rsp_rdata = '0; out_rsp_error = 0; out_rsp_ready = 0;
        repeat (3) tick();
        check("rst_grant", grant_o, 0);
        check("rst_out_valid", out_req_valid, 0);
        check("rst_addr", out_req_addr, 0);
        check("rst_rsp_ready", in_rsp_ready, 0);
        check("rst_timeout", timeout_o, 0);
        rst_ni = 1;

        // Single write from requester 2, bridge answers 3 cycles after out_req_valid.
        set_req(2, 1'b1, 64'h1000, 64'hA5, 8'h0F);
        in_req_valid = 4'b0100;
        tick();
        in_req_valid = 4'b0000;
        #1;
        check("t1_grant", grant_o, 4'b0100);
        check("t1_out_valid", out_req_valid, 1);
        check("t1_addr", out_req_addr, 64'h1000);
        check("t1_wdata", out_req_wdata, 64'hA5);
        check("t1_wstrb", out_req_wstrb, 8'h0F);
        check("t1_write", out_req_write, 1);
        check("t1_no_rdy0", in_rsp_ready, 0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check("t1_no_rdy", in_rsp_ready, 0);
        end
        tick();
        out_rsp_ready = 1;
        #1;
        check("t1_rdy", in_rsp_ready, 4'b0100);
        check("t1_err", in_rsp_error, 0);
        tick();
        out_rsp_ready = 0;
        #1;
        check("t1_after_rdy", in_rsp_ready, 0);
        check("t1_after_grant", grant_o, 0);

        // Pointer now sits at 3: requests on 1 and 3 must serve 3 first.
        set_req(1, 1'b0, 64'h2000, 64'h11, 8'hFF);
        set_req(3, 1'b0, 64'h3000, 64'h33, 8'hFF);
        in_req_valid = 4'b1010;
        tick();
        #1;
        check("t3_first", grant_o, 4'b1000);
        out_rsp_ready = 1;
        #1;
        check("t3_rdy_first", in_rsp_ready, 4'b1000);
        tick();
        out_rsp_ready = 0;
        in_req_valid = 4'b0010;
        #1;
        check("t3_bubble", grant_o, 0);
        tick();
        #1;
        check("t3_second", grant_o, 4'b0010);
        check("t3_addr", out_req_addr, 64'h2000);
        out_rsp_ready = 1;
        #1;
        check("t3_rdy_second", in_rsp_ready, 4'b0010);
        tick();
        out_rsp_ready = 0;
        in_req_valid = 0;

        // All four requesting from reset, bridge ready on the second busy cycle.
        rst_ni = 0;
        repeat (2) tick();
        rst_ni = 1;
        in_req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("t2_grant", grant_o, 4'b0001 << (k % 4));
            tick();
            out_rsp_ready = 1;
            #1;
            check("t2_rdy", in_rsp_ready, 4'b0001 << (k % 4));
            tick();
            out_rsp_ready = 0;
            if (k == 4) in_req_valid = 0;
            #1;
            check("t2_bubble", grant_o, 0);
        end

        // Reset in the middle of a transaction; arbitration restarts at index 0.
        in_req_valid = 4'b0100;
        tick();
        in_req_valid = 0;
        #1;
        check("t6_busy", grant_o, 4'b0100);
        tick();
        rst_ni = 0;
        tick();
        check("t6_out_valid", out_req_valid, 0);
        check("t6_grant", grant_o, 0);
        check("t6_rdy", in_rsp_ready, 0);
        rst_ni = 1;
        in_req_valid = 4'b1001;
        tick();
        #1;
        check("t6_restart", grant_o, 4'b0001);
        out_rsp_ready = 1;
        in_req_valid = 0;
        tick();
        out_rsp_ready = 0;

        // Watchdog: bridge silent, error on busy cycle 8, then drain until cycle 20.
        in_req_valid = 4'b0010;
        tick();
        in_req_valid = 0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            check("t4_wait_rdy", in_rsp_ready, 0);
            check("t4_wait_tmo", timeout_o, 0);
            tick();
        end
        #1;
        check("t4_rdy", in_rsp_ready, 4'b0010);
        check("t4_err", in_rsp_error, 4'b0010);
        check("t4_tmo", timeout_o, 1);
        check("t4_rdata", in_rsp_rdata, 0);
        for (int k = 9; k <= 19; k++) begin
            tick();
            check("t4_drain_valid", out_req_valid, 1);
            check("t4_drain_grant", grant_o, 4'b0010);
            check("t4_drain_rdy", in_rsp_ready, 0);
            check("t4_drain_tmo", timeout_o, 0);
        end
        tick();
        out_rsp_ready = 1;
        out_rsp_error = 1;
        #1;
        check("t4_discard_rdy", in_rsp_ready, 0);
        check("t4_discard_err", in_rsp_error, 0);
        tick();
        out_rsp_ready = 0;
        out_rsp_error = 0;
        #1;
        check("t4_idle_valid", out_req_valid, 0);
        tick();
        check("t4_no_second", in_rsp_ready, 0);

        // Bridge answers exactly on the expiry cycle: normal completion wins.
        in_req_valid = 4'b0100;
        tick();
        in_req_valid = 0;
        repeat (7) tick();
        out_rsp_ready = 1;
        out_rsp_rdata = 64'hDEAD_BEEF_0123_4567;
        #1;
        exp_rd = '0;
        exp_rd[2*DW +: DW] = 64'hDEAD_BEEF_0123_4567;
        check("t5_rdy", in_rsp_ready, 4'b0100);
        check("t5_tmo", timeout_o, 0);
        check("t5_err", in_rsp_error, 0);
        check("t5_rdata", in_rsp_rdata, exp_rd);
        tick();
        out_rsp_ready = 0;
        #1;
        check("t5_idle_valid", out_req_valid, 0);

        // Random traffic, including bridge ready in IDLE and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst_ni       = ($urandom_range(0, 599) != 0);
            in_req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            in_req_write = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                in_req_addr[i*AW +: AW]  = {$urandom, $urandom};
                in_req_wdata[i*DW +: DW] = {$urandom, $urandom};
                in_req_wstrb[i*8 +: 8]   = 8'($urandom);
            end
            out_rsp_ready = ($urandom_range(0, 4) == 0);
            out_rsp_error = 1'($urandom);
            out_rsp_rdata = {$urandom, $urandom};
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
